// File: rtl/piece_dispenser_if.sv
// Bag handshake toward the generator plus the piece/preview feed toward the game controller.
// The dispenser sits on the slave modport; the bench or surrounding logic takes the master side.
interface piece_dispenser_if #(
  parameter int NPIECES = 7,
  parameter int PW      = 3
);
  logic                    newbag;
  logic                    bag_ready;
  logic [NPIECES*PW-1:0]   bag;
  logic                    take;
  logic [PW-1:0]           piece;
  logic                    piece_valid;
  logic [PW-1:0]           preview;
  logic                    preview_valid;
  logic                    bag_err;
  logic [7:0]              err_count;

  modport slave (
    output newbag,
    input  bag_ready,
    input  bag,
    input  take,
    output piece,
    output piece_valid,
    output preview,
    output preview_valid,
    output bag_err,
    output err_count
  );

  modport master (
    input  newbag,
    output bag_ready,
    output bag,
    output take,
    input  piece,
    input  piece_valid,
    input  preview,
    input  preview_valid,
    input  bag_err,
    input  err_count
  );
endinterface

// File: rtl/piece_dispenser.sv
// 7-bag consumer: requests bags, rejects anything that is not a permutation of 0..NPIECES-1,
// and dispenses pieces from an ACTIVE/SPARE double buffer with a one-piece preview.
module piece_dispenser #(
  parameter int NPIECES = 7,
  parameter int PW      = 3
) (
  input  logic              clk,
  input  logic              nreset,
  piece_dispenser_if.slave  bus
);

  localparam int IW     = $clog2(NPIECES);
  localparam int NCODES = 2 ** PW;
  localparam logic [IW-1:0]     LAST_IDX  = IW'(NPIECES - 1);
  localparam logic [NCODES-1:0] FULL_MASK = NCODES'((1 << NPIECES) - 1);

  typedef logic [NPIECES-1:0][PW-1:0] bag_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ARM,
    CHECK
  } state_t;

  state_t      state_q, state_d;
  logic        newbag_q, newbag_d;
  logic        bag_err_q, bag_err_d;
  logic [7:0]  err_count_q, err_count_d;
  bag_t        bag_q, bag_d;
  bag_t        active_q, active_d;
  bag_t        spare_q, spare_d;
  logic        active_full_q, active_full_d;
  logic        spare_full_q, spare_full_d;
  logic [IW-1:0] index_q, index_d;

  logic              bag_ok;
  logic              take_ok;
  logic              at_last;
  logic [IW-1:0]     next_idx;
  logic [NCODES-1:0] slot_hot [NPIECES];
  logic [NCODES-1:0] code_mask;

  // A bag is a permutation exactly when the per-slot one-hot codes cover 0..NPIECES-1
  // and nothing else; duplicates leave a hole and code 7 sets a bit outside the mask.
  generate
    for (genvar gi = 0; gi < NPIECES; gi++) begin : g_slot_hot
      assign slot_hot[gi] = NCODES'(1) << bag_q[gi];
    end
  endgenerate

  always_comb begin
    code_mask = '0;
    for (int k = 0; k < NPIECES; k++) begin
      code_mask = code_mask | slot_hot[k];
    end
  end

  assign bag_ok = (code_mask == FULL_MASK);

  always_comb begin
    state_d     = state_q;
    bag_d       = bag_q;
    bag_err_d   = 1'b0;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (!active_full_q || !spare_full_q) state_d = REQ;
      end
      REQ: begin
        if (!bus.bag_ready) state_d = ARM;
      end
      ARM: begin
        if (bus.bag_ready) begin
          bag_d   = bus.bag;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (bag_ok) begin
          state_d = IDLE;
        end else begin
          state_d   = REQ;
          bag_err_d = 1'b1;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    newbag_d = (state_d == REQ) || (state_d == ARM);
  end

  assign take_ok  = bus.take && active_full_q;
  assign at_last  = (index_q == LAST_IDX);
  assign next_idx = index_q + IW'(1);

  always_comb begin
    active_d      = active_q;
    active_full_d = active_full_q;
    spare_d       = spare_q;
    spare_full_d  = spare_full_q;
    index_d       = index_q;
    if (take_ok) begin
      if (!at_last) begin
        index_d = next_idx;
      end else begin
        index_d = '0;
        if (spare_full_q) begin
          active_d     = spare_q;
          spare_full_d = 1'b0;
        end else begin
          active_full_d = 1'b0;
        end
      end
    end
    // Placement uses the post-take view so a swap frees SPARE for the incoming bag.
    if ((state_q == CHECK) && bag_ok) begin
      if (!active_full_d) begin
        active_d      = bag_q;
        active_full_d = 1'b1;
        index_d       = '0;
      end else begin
        spare_d      = bag_q;
        spare_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q       <= IDLE;
      newbag_q      <= 1'b0;
      bag_err_q     <= 1'b0;
      err_count_q   <= '0;
      bag_q         <= '0;
      active_q      <= '0;
      spare_q       <= '0;
      active_full_q <= 1'b0;
      spare_full_q  <= 1'b0;
      index_q       <= '0;
    end else begin
      state_q       <= state_d;
      newbag_q      <= newbag_d;
      bag_err_q     <= bag_err_d;
      err_count_q   <= err_count_d;
      bag_q         <= bag_d;
      active_q      <= active_d;
      spare_q       <= spare_d;
      active_full_q <= active_full_d;
      spare_full_q  <= spare_full_d;
      index_q       <= index_d;
    end
  end

  always_comb begin
    bus.piece         = '0;
    bus.piece_valid   = active_full_q;
    bus.preview       = '0;
    bus.preview_valid = 1'b0;
    if (active_full_q) begin
      bus.piece = active_q[index_q];
      if (!at_last) begin
        bus.preview       = active_q[next_idx];
        bus.preview_valid = 1'b1;
      end else if (spare_full_q) begin
        bus.preview       = spare_q[0];
        bus.preview_valid = 1'b1;
      end
    end
  end

  assign bus.newbag    = newbag_q;
  assign bus.bag_err   = bag_err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_piece_dispenser.sv
// Directed bench for piece_dispenser: the bench plays the bag generator and the controller
// cycle by cycle, with expected values worked out by hand from the bag contents.
module tb_piece_dispenser;

  logic clk;
  logic nreset;
  int   n_vec;
  int   n_miscompare;

  piece_dispenser_if bus ();

  piece_dispenser dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [20:0] BAG_A   = 21'h12A18B; // 3,1,6,0,2,5,4
  localparam logic [20:0] BAG_B   = 21'h1AC688; // 0,1,2,3,4,5,6
  localparam logic [20:0] BAG_DUP = 21'h12A189; // slot 0 = 1, duplicate of slot 1
  localparam logic [20:0] BAG_Z   = 21'h000000;

  logic [2:0] seq_a [7] = '{3'd3, 3'd1, 3'd6, 3'd0, 3'd2, 3'd5, 3'd4};
  logic [2:0] seq_b [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_piece(input string tag, input logic pv, input logic [2:0] p,
                             input logic prv, input logic [2:0] pr);
    check_eq({tag, ".piece_valid"}, 32'(bus.piece_valid), 32'(pv));
    check_eq({tag, ".piece"}, 32'(bus.piece), 32'(p));
    check_eq({tag, ".preview_valid"}, 32'(bus.preview_valid), 32'(prv));
    check_eq({tag, ".preview"}, 32'(bus.preview), 32'(pr));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".newbag"}, 32'(bus.newbag), 32'd0);
    check_eq({tag, ".bag_err"}, 32'(bus.bag_err), 32'd0);
    check_eq({tag, ".err_count"}, 32'(bus.err_count), 32'd0);
    check_piece(tag, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  initial begin
    n_vec         = 0;
    n_miscompare  = 0;
    nreset        = 1'b0;
    bus.bag_ready = 1'b0;
    bus.bag       = '0;
    bus.take      = 1'b0;

    // Reset, then the first fill with the generator slow to respond.
    tick();
    check_reset_outputs("reset");
    nreset = 1'b1;
    tick();
    check_eq("fill.newbag_c1", 32'(bus.newbag), 32'd1);
    tick();
    tick();
    check_eq("fill.newbag_wait", 32'(bus.newbag), 32'd1);
    check_eq("fill.empty_wait", 32'(bus.piece_valid), 32'd0);
    bus.bag_ready = 1'b1;
    bus.bag       = BAG_A;
    tick();
    check_eq("fill.newbag_check", 32'(bus.newbag), 32'd0);
    check_eq("fill.empty_check", 32'(bus.piece_valid), 32'd0);
    bus.bag_ready = 1'b1; // stays high: stale ready for the next request
    tick();
    check_piece("fill.loaded", 1'b1, 3'd3, 1'b1, 3'd1);

    // Stale ready: the second request must wait for ready to drop first.
    tick();
    check_eq("stale.newbag_rise", 32'(bus.newbag), 32'd1);
    tick();
    tick();
    check_eq("stale.held_req", 32'(bus.newbag), 32'd1);
    bus.bag_ready = 1'b0;
    tick();
    check_eq("stale.arm", 32'(bus.newbag), 32'd1);
    bus.bag_ready = 1'b1;
    bus.bag       = BAG_A;
    tick();
    check_eq("stale.check", 32'(bus.newbag), 32'd0);
    bus.bag_ready = 1'b0;
    tick();
    tick();
    check_eq("steady.newbag", 32'(bus.newbag), 32'd0);

    // Seven takes through ACTIVE; preview at the last slot comes from SPARE.
    bus.take = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 6) check_piece($sformatf("disp.%0d", i), 1'b1, seq_a[i], 1'b1, seq_a[i+1]);
      else       check_piece($sformatf("disp.%0d", i), 1'b1, seq_a[i], 1'b1, seq_a[0]);
      tick();
    end
    bus.take = 1'b0;
    check_piece("disp.swap", 1'b1, 3'd3, 1'b1, 3'd1);
    tick();
    check_eq("disp.newbag_again", 32'(bus.newbag), 32'd1);

    // All-zero bag and a duplicate-code bag are both rejected.
    tick();
    bus.bag_ready = 1'b1;
    bus.bag       = BAG_Z;
    tick();
    bus.bag_ready = 1'b0;
    check_eq("bad0.err_pre", 32'(bus.bag_err), 32'd0);
    tick();
    check_eq("bad0.bag_err", 32'(bus.bag_err), 32'd1);
    check_eq("bad0.err_count", 32'(bus.err_count), 32'd1);
    check_eq("bad0.newbag", 32'(bus.newbag), 32'd1);
    check_piece("bad0.buffers", 1'b1, 3'd3, 1'b1, 3'd1);
    tick();
    check_eq("bad0.err_pulse_end", 32'(bus.bag_err), 32'd0);
    bus.bag_ready = 1'b1;
    bus.bag       = BAG_DUP;
    tick();
    bus.bag_ready = 1'b0;
    tick();
    check_eq("bad1.bag_err", 32'(bus.bag_err), 32'd1);
    check_eq("bad1.err_count", 32'(bus.err_count), 32'd2);
    tick();

    // Fill SPARE with BAG_B, then stall the generator and drain 14 pieces.
    bus.bag_ready = 1'b1;
    bus.bag       = BAG_B;
    tick();
    bus.bag_ready = 1'b0;
    tick();
    check_eq("starve.full_newbag", 32'(bus.newbag), 32'd0);
    bus.take = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i < 6)       check_piece($sformatf("starve.%0d", i), 1'b1, seq_a[i], 1'b1, seq_a[i+1]);
      else if (i == 6) check_piece($sformatf("starve.%0d", i), 1'b1, seq_a[6], 1'b1, seq_b[0]);
      else if (i < 13) check_piece($sformatf("starve.%0d", i), 1'b1, seq_b[i-7], 1'b1, seq_b[i-6]);
      else             check_piece($sformatf("starve.%0d", i), 1'b1, seq_b[6], 1'b0, 3'd0);
      tick();
    end
    check_piece("starve.empty", 1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    bus.take = 1'b0;
    check_piece("starve.take15", 1'b0, 3'd0, 1'b0, 3'd0);
    check_eq("starve.newbag", 32'(bus.newbag), 32'd1);
    bus.bag_ready = 1'b1;
    bus.bag       = BAG_A;
    tick();
    bus.bag_ready = 1'b0;
    tick();
    check_piece("starve.reload_idx0", 1'b1, 3'd3, 1'b1, 3'd1);

    // Reset while ARMed with ready high: the pending bag must never load.
    tick();
    tick();
    check_eq("rst.armed", 32'(bus.newbag), 32'd1);
    bus.bag_ready = 1'b1;
    bus.bag       = BAG_B;
    nreset        = 1'b0;
    tick();
    check_reset_outputs("rst.mid_arm");
    nreset = 1'b1;
    tick();
    check_eq("rst.newbag_c1", 32'(bus.newbag), 32'd1);
    tick();
    check_eq("rst.no_stale_load", 32'(bus.piece_valid), 32'd0);
    bus.bag_ready = 1'b0;
    tick();
    bus.bag_ready = 1'b1;
    bus.bag       = BAG_A;
    tick();
    bus.bag_ready = 1'b0;
    tick();
    check_piece("rst.fresh_load", 1'b1, 3'd3, 1'b1, 3'd1);
    check_eq("rst.err_count", 32'(bus.err_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
